// File: rtl/fu_result_arbiter_pkg.sv
// Shared sizes and payload types for FU result collection and CDB broadcast.
package fu_result_arbiter_pkg;

    localparam int unsigned NUM_FU      = 4;
    localparam int unsigned CDB_WIDTH   = 2;
    localparam int unsigned ROB_TAG_W   = 5;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned CDB_FU_ID_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
        logic                 cond;
    } FU_RESULT_ENTRY;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_W-1:0]   tag;
        logic [XLEN-1:0]        value;
        logic                   cond;
        logic [CDB_FU_ID_W-1:0] fu_id;
    } CDB_PACKET;

endpackage

// File: rtl/fu_result_fifo.sv
// Per-FU circular result FIFO; a push into a full FIFO without a pop is dropped.
module fu_result_fifo
    import fu_result_arbiter_pkg::*;
#(
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             push,
    input  logic             pop,
    input  FU_RESULT_ENTRY   din,
    output FU_RESULT_ENTRY   head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    FU_RESULT_ENTRY   mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push into a full FIFO is then legal.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q];
    assign count   = count_q;

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fu_result_arbiter.sv
// Round-robin collection of FU results onto CDB_WIDTH broadcast ports.
// Optional same-cycle FIFO bypass for idle FUs: define FU_ARB_BYPASS_EN.
module fu_result_arbiter #(
    parameter int unsigned  NUM_FU     = fu_result_arbiter_pkg::NUM_FU,
    parameter int unsigned  CDB_WIDTH  = fu_result_arbiter_pkg::CDB_WIDTH,
    parameter int unsigned  FIFO_DEPTH = 2,
    parameter int unsigned  TAG_W      = fu_result_arbiter_pkg::ROB_TAG_W,
    localparam int unsigned FU_ID_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   squash,
    input  logic [NUM_FU-1:0]                                      fu_valid,
    input  logic [NUM_FU-1:0][fu_result_arbiter_pkg::XLEN-1:0]     fu_value,
    input  logic [NUM_FU-1:0][TAG_W-1:0]                           fu_tag,
    input  logic [NUM_FU-1:0]                                      fu_cond,
    output logic [NUM_FU-1:0]                                      fu_stall,
    output logic [CDB_WIDTH-1:0]                                   cdb_valid,
    output logic [CDB_WIDTH-1:0][fu_result_arbiter_pkg::XLEN-1:0]  cdb_value,
    output logic [CDB_WIDTH-1:0][TAG_W-1:0]                        cdb_tag,
    output logic [CDB_WIDTH-1:0]                                   cdb_cond,
    output logic [CDB_WIDTH-1:0][FU_ID_W-1:0]                      cdb_fu_id
);

    import fu_result_arbiter_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NXT_W = CNT_W + 1;
    localparam int unsigned SUM_W = FU_ID_W + 1;

    FU_RESULT_ENTRY     fu_entry   [NUM_FU];
    FU_RESULT_ENTRY     fifo_head  [NUM_FU];
    logic [CNT_W-1:0]   fifo_count [NUM_FU];
    logic [NUM_FU-1:0]  fifo_empty;
    logic [NUM_FU-1:0]  fifo_full;
    logic [NUM_FU-1:0]  bypass;
    logic [NUM_FU-1:0]  eligible;
    logic [NUM_FU-1:0]  grant;
    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  pop;
    logic [FU_ID_W-1:0] rr_q;
    logic [FU_ID_W-1:0] rr_d;
    logic [NUM_FU-1:0]  stall_q;
    logic [NUM_FU-1:0]  stall_d;
    CDB_PACKET          cdb_q [CDB_WIDTH];
    CDB_PACKET          cdb_d [CDB_WIDTH];

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign fu_entry[i] = '{tag: ROB_TAG_W'(fu_tag[i]), value: fu_value[i], cond: fu_cond[i]};
`ifdef FU_ARB_BYPASS_EN
        assign bypass[i] = fifo_empty[i] & fu_valid[i];
`else
        assign bypass[i] = 1'b0;
`endif
        assign eligible[i] = ~fifo_empty[i] | bypass[i];
        // A bypassed grant goes straight to the CDB and never occupies the FIFO.
        assign push[i] = fu_valid[i] & ~(grant[i] & bypass[i]);
        assign pop[i]  = grant[i] & ~bypass[i];

        fu_result_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock  (clock),
            .reset  (reset),
            .squash (squash),
            .push   (push[i]),
            .pop    (pop[i]),
            .din    (fu_entry[i]),
            .head   (fifo_head[i]),
            .count  (fifo_count[i]),
            .empty  (fifo_empty[i]),
            .full   (fifo_full[i])
        );

        a_no_overflow: assert property (@(posedge clock) disable iff (reset || squash)
            !(push[i] && fifo_full[i] && !pop[i]));
    end

    // Scan from rr_q, granting the first CDB_WIDTH eligible FUs onto ports in order.
    always_comb begin
        int unsigned        n;
        logic [SUM_W-1:0]   sum;
        logic [FU_ID_W-1:0] idx;
        FU_RESULT_ENTRY     src;
        n     = 0;
        sum   = '0;
        idx   = '0;
        src   = '0;
        grant = '0;
        rr_d  = rr_q;
        for (int unsigned p = 0; p < CDB_WIDTH; p++) begin
            cdb_d[p] = '0;
        end
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, rr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_FU)) begin
                sum = sum - SUM_W'(NUM_FU);
            end
            idx = sum[FU_ID_W-1:0];
            if (eligible[idx] && n < CDB_WIDTH) begin
                src        = bypass[idx] ? fu_entry[idx] : fifo_head[idx];
                grant[idx] = 1'b1;
                for (int unsigned p = 0; p < CDB_WIDTH; p++) begin
                    if (n == p) begin
                        cdb_d[p] = '{valid: 1'b1, tag: src.tag, value: src.value,
                                     cond: src.cond, fu_id: CDB_FU_ID_W'(idx)};
                    end
                end
                n    = n + 1;
                rr_d = (idx == FU_ID_W'(NUM_FU - 1)) ? '0 : idx + FU_ID_W'(1);
            end
        end
    end

    // Stall one slot early so a 1-cycle FU's in-flight result still fits.
    always_comb begin
        logic [NXT_W-1:0] nxt;
        nxt     = '0;
        stall_d = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            nxt        = {1'b0, fifo_count[i]} + NXT_W'(fu_valid[i]) - NXT_W'(grant[i]);
            stall_d[i] = (nxt >= NXT_W'(FIFO_DEPTH - 1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q    <= '0;
            stall_q <= '0;
            for (int unsigned p = 0; p < CDB_WIDTH; p++) begin
                cdb_q[p] <= '0;
            end
        end else if (squash) begin
            stall_q <= '0;
            for (int unsigned p = 0; p < CDB_WIDTH; p++) begin
                cdb_q[p] <= '0;
            end
        end else begin
            rr_q    <= rr_d;
            stall_q <= stall_d;
            cdb_q   <= cdb_d;
        end
    end

    for (genvar p = 0; p < CDB_WIDTH; p++) begin : g_cdb
        assign cdb_valid[p] = cdb_q[p].valid;
        assign cdb_value[p] = cdb_q[p].value;
        assign cdb_tag[p]   = TAG_W'(cdb_q[p].tag);
        assign cdb_cond[p]  = cdb_q[p].cond;
        assign cdb_fu_id[p] = FU_ID_W'(cdb_q[p].fu_id);
    end

    assign fu_stall = stall_q;

endmodule
